// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants and parser state encoding for the Ethernet header parser
// Purpose: EtherType/TPID constants, broadcast MAC and the FSM state enum used by eth_header_parser.
// Ports: none (package).
package eth_pkg;

   localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ETH_TPID_VLAN = 16'h8100;
   localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [3:0] {
      ST_GAP     = 4'd0,
      ST_IDLE    = 4'd1,
      ST_DA      = 4'd2,
      ST_SA      = 4'd3,
      ST_TYPE    = 4'd4,
      ST_TCI     = 4'd5,
      ST_ITYPE   = 4'd6,
      ST_PAYLOAD = 4'd7,
      ST_DROP    = 4'd8
   } eth_state_e;

endpackage

// File: rtl/eth_header_parser.sv
// rtl/eth_header_parser.sv - byte-serial Ethernet header parser, MAC filter, classifier and payload forwarder
// Purpose: splits DA/SA/optional 802.1Q tag/EtherType from the MAC receive byte stream,
//          classifies the frame as IP/ARP/invalid and forwards payload bytes one cycle later.
// Ports:
//   clock, sclr                  clock and synchronous active-high reset
//   datain, data_en              frame byte stream, data_en high for the whole frame
//   local_mac                    board MAC used by the destination filter
//   BOARD_MAC, PC_MAC            captured destination / source MAC
//   ethertype, vlan_valid, vlan_id  parsed type and tag fields
//   isIp, isARP, isNotAValidPacket  classification levels, held until data_en falls
//   payload_data/valid/sop/len   forwarded payload stream and byte count
//   hdr_runt                     pulse when the frame ends inside the header
module eth_header_parser
   import eth_pkg::*;
#(
   parameter int VLAN_EN       = 1,
   parameter int MAC_FILTER_EN = 1,
   parameter int LEN_W         = 11
) (
   input  logic             clock,
   input  logic             sclr,
   input  logic [7:0]       datain,
   input  logic             data_en,
   input  logic [47:0]      local_mac,
   output logic [47:0]      BOARD_MAC,
   output logic [47:0]      PC_MAC,
   output logic [15:0]      ethertype,
   output logic             vlan_valid,
   output logic [11:0]      vlan_id,
   output logic             isIp,
   output logic             isARP,
   output logic             isNotAValidPacket,
   output logic [7:0]       payload_data,
   output logic             payload_valid,
   output logic             payload_sop,
   output logic [LEN_W-1:0] payload_len,
   output logic             hdr_runt
);

   eth_state_e       state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [47:0]      board_mac_q, board_mac_d;
   logic [47:0]      pc_mac_q, pc_mac_d;
   logic [15:0]      ethertype_q, ethertype_d;
   logic             vlan_valid_q, vlan_valid_d;
   logic [11:0]      vlan_id_q, vlan_id_d;
   logic             is_ip_q, is_ip_d;
   logic             is_arp_q, is_arp_d;
   logic             is_bad_q, is_bad_d;
   logic [7:0]       pl_data_q, pl_data_d;
   logic             pl_valid_q, pl_valid_d;
   logic             pl_sop_q, pl_sop_d;
   logic [LEN_W-1:0] pl_len_q, pl_len_d;
   logic             runt_q, runt_d;

   logic [15:0]      type_shift;
   logic             mac_ok;
   logic             decide;

   assign type_shift = {ethertype_q[7:0], datain};
   assign mac_ok     = (MAC_FILTER_EN == 0) || (board_mac_q == local_mac) || (board_mac_q == MAC_BCAST);
   // The cycle after the last type byte is the decision cycle; it is still in TYPE/ITYPE
   // and its byte (if any) is already the first payload byte.
   assign decide     = ((state_q == ST_TYPE) && (cnt_q == 5'd14)) ||
                       ((state_q == ST_ITYPE) && (cnt_q == 5'd18));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      board_mac_d  = board_mac_q;
      pc_mac_d     = pc_mac_q;
      ethertype_d  = ethertype_q;
      vlan_valid_d = vlan_valid_q;
      vlan_id_d    = vlan_id_q;
      is_ip_d      = is_ip_q;
      is_arp_d     = is_arp_q;
      is_bad_d     = is_bad_q;
      pl_data_d    = pl_data_q;
      pl_valid_d   = 1'b0;
      pl_sop_d     = 1'b0;
      pl_len_d     = pl_len_q;
      runt_d       = 1'b0;

      // Classification levels drop on the first cycle without data_en.
      if (!data_en) begin
         is_ip_d  = 1'b0;
         is_arp_d = 1'b0;
         is_bad_d = 1'b0;
      end

      case (state_q)
         ST_GAP: begin
            if (!data_en) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            is_ip_d  = 1'b0;
            is_arp_d = 1'b0;
            is_bad_d = 1'b0;
            if (data_en) begin
               board_mac_d  = {board_mac_q[39:0], datain};
               vlan_valid_d = 1'b0;
               vlan_id_d    = 12'd0;
               cnt_d        = 5'd1;
               state_d      = ST_DA;
            end
         end
         ST_DA: begin
            if (!data_en) begin
               runt_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               board_mac_d = {board_mac_q[39:0], datain};
               cnt_d       = cnt_q + 5'd1;
               if (cnt_q == 5'd5) state_d = ST_SA;
            end
         end
         ST_SA: begin
            if (!data_en) begin
               runt_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               pc_mac_d = {pc_mac_q[39:0], datain};
               cnt_d    = cnt_q + 5'd1;
               if (cnt_q == 5'd11) state_d = ST_TYPE;
            end
         end
         ST_TYPE: begin
            if (!decide) begin
               if (!data_en) begin
                  runt_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ethertype_d = type_shift;
                  cnt_d       = cnt_q + 5'd1;
                  if ((cnt_q == 5'd13) && (VLAN_EN != 0) && (type_shift == ETH_TPID_VLAN)) begin
                     vlan_valid_d = 1'b1;
                     state_d      = ST_TCI;
                  end
               end
            end
         end
         ST_TCI: begin
            if (!data_en) begin
               runt_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd14) begin
                  vlan_id_d[11:8] = datain[3:0];
               end else begin
                  vlan_id_d[7:0] = datain;
                  state_d        = ST_ITYPE;
               end
            end
         end
         ST_ITYPE: begin
            if (!decide) begin
               if (!data_en) begin
                  runt_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ethertype_d = type_shift;
                  cnt_d       = cnt_q + 5'd1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (!data_en) begin
               state_d = ST_IDLE;
            end else begin
               pl_data_d  = datain;
               pl_valid_d = 1'b1;
               if (pl_len_q != {LEN_W{1'b1}}) pl_len_d = pl_len_q + 1'b1;
            end
         end
         ST_DROP: begin
            if (!data_en) state_d = ST_IDLE;
         end
         default: state_d = ST_GAP;
      endcase

      if (decide) begin
         if (mac_ok && ((ethertype_q == ETH_TYPE_IP) || (ethertype_q == ETH_TYPE_ARP))) begin
            is_ip_d  = (ethertype_q == ETH_TYPE_IP);
            is_arp_d = (ethertype_q == ETH_TYPE_ARP);
            if (data_en) begin
               pl_data_d  = datain;
               pl_valid_d = 1'b1;
               pl_sop_d   = 1'b1;
               pl_len_d   = LEN_W'(1);
               state_d    = ST_PAYLOAD;
            end else begin
               pl_len_d = '0;
               state_d  = ST_IDLE;
            end
         end else begin
            is_bad_d = 1'b1;
            state_d  = data_en ? ST_DROP : ST_IDLE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         state_q      <= ST_GAP;
         cnt_q        <= 5'd0;
         board_mac_q  <= 48'd0;
         pc_mac_q     <= 48'd0;
         ethertype_q  <= 16'd0;
         vlan_valid_q <= 1'b0;
         vlan_id_q    <= 12'd0;
         is_ip_q      <= 1'b0;
         is_arp_q     <= 1'b0;
         is_bad_q     <= 1'b0;
         pl_data_q    <= 8'd0;
         pl_valid_q   <= 1'b0;
         pl_sop_q     <= 1'b0;
         pl_len_q     <= '0;
         runt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         board_mac_q  <= board_mac_d;
         pc_mac_q     <= pc_mac_d;
         ethertype_q  <= ethertype_d;
         vlan_valid_q <= vlan_valid_d;
         vlan_id_q    <= vlan_id_d;
         is_ip_q      <= is_ip_d;
         is_arp_q     <= is_arp_d;
         is_bad_q     <= is_bad_d;
         pl_data_q    <= pl_data_d;
         pl_valid_q   <= pl_valid_d;
         pl_sop_q     <= pl_sop_d;
         pl_len_q     <= pl_len_d;
         runt_q       <= runt_d;
      end
   end

   assign BOARD_MAC         = board_mac_q;
   assign PC_MAC            = pc_mac_q;
   assign ethertype         = ethertype_q;
   assign vlan_valid        = vlan_valid_q;
   assign vlan_id           = vlan_id_q;
   assign isIp              = is_ip_q;
   assign isARP             = is_arp_q;
   assign isNotAValidPacket = is_bad_q;
   assign payload_data      = pl_data_q;
   assign payload_valid     = pl_valid_q;
   assign payload_sop       = pl_sop_q;
   assign payload_len       = pl_len_q;
   assign hdr_runt          = runt_q;

endmodule

// File: tb/tb_eth_header_parser.sv
// tb/tb_eth_header_parser.sv - directed self-checking bench for eth_header_parser
module tb_eth_header_parser;

   localparam logic [47:0] LMAC = 48'h001A_2B3C_4D5E;
   localparam logic [47:0] SMAC = 48'h1122_3344_5566;

   logic        clock = 1'b0;
   logic        sclr = 1'b0;
   logic [7:0]  datain = 8'd0;
   logic        data_en = 1'b0;
   logic [47:0] local_mac = LMAC;

   logic [47:0] board_mac, pc_mac;
   logic [15:0] ethertype;
   logic        vlan_valid;
   logic [11:0] vlan_id;
   logic        is_ip, is_arp, is_bad;
   logic [7:0]  pl_data;
   logic        pl_valid, pl_sop;
   logic [10:0] pl_len;
   logic        runt;

   logic [47:0] board_mac_n, pc_mac_n;
   logic [15:0] ethertype_n;
   logic        vlan_valid_n;
   logic [11:0] vlan_id_n;
   logic        is_ip_n, is_arp_n, is_bad_n;
   logic [7:0]  pl_data_n;
   logic        pl_valid_n, pl_sop_n;
   logic [10:0] pl_len_n;
   logic        runt_n;

   always #5 clock = ~clock;

   eth_header_parser #(.VLAN_EN(1), .MAC_FILTER_EN(1), .LEN_W(11)) u_dut (
      .clock(clock), .sclr(sclr), .datain(datain), .data_en(data_en), .local_mac(local_mac),
      .BOARD_MAC(board_mac), .PC_MAC(pc_mac), .ethertype(ethertype), .vlan_valid(vlan_valid),
      .vlan_id(vlan_id), .isIp(is_ip), .isARP(is_arp), .isNotAValidPacket(is_bad),
      .payload_data(pl_data), .payload_valid(pl_valid), .payload_sop(pl_sop),
      .payload_len(pl_len), .hdr_runt(runt));

   eth_header_parser #(.VLAN_EN(1), .MAC_FILTER_EN(0), .LEN_W(11)) u_nof (
      .clock(clock), .sclr(sclr), .datain(datain), .data_en(data_en), .local_mac(local_mac),
      .BOARD_MAC(board_mac_n), .PC_MAC(pc_mac_n), .ethertype(ethertype_n), .vlan_valid(vlan_valid_n),
      .vlan_id(vlan_id_n), .isIp(is_ip_n), .isARP(is_arp_n), .isNotAValidPacket(is_bad_n),
      .payload_data(pl_data_n), .payload_valid(pl_valid_n), .payload_sop(pl_sop_n),
      .payload_len(pl_len_n), .hdr_runt(runt_n));

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] fr[$];
   int hdr_len;
   int n_valid, n_sop, n_runt, seq_err, multi_err, first_ip_idx;
   logic [7:0] first_pl;
   logic [10:0] len_at_sop;
   logic saw_ip, saw_arp, saw_bad, saw_ip_n, ip_at_last, flag_after_end;

   task automatic reset_mon();
      n_valid = 0; n_sop = 0; n_runt = 0; seq_err = 0; multi_err = 0; first_ip_idx = -1;
      first_pl = 8'hxx; len_at_sop = 11'h0;
      saw_ip = 1'b0; saw_arp = 1'b0; saw_bad = 1'b0; saw_ip_n = 1'b0;
   endtask

   task automatic observe(input int idx);
      if (pl_valid) begin
         if ((hdr_len + n_valid) >= fr.size() || pl_data !== fr[hdr_len + n_valid]) seq_err++;
         n_valid++;
      end
      if (pl_sop) begin
         n_sop++;
         first_pl = pl_data;
         len_at_sop = pl_len;
      end
      if (is_ip && first_ip_idx < 0) first_ip_idx = idx;
      if (is_ip) saw_ip = 1'b1;
      if (is_arp) saw_arp = 1'b1;
      if (is_bad) saw_bad = 1'b1;
      if (is_ip_n) saw_ip_n = 1'b1;
      if (runt) n_runt++;
      if ((int'(is_ip) + int'(is_arp) + int'(is_bad)) > 1) multi_err++;
   endtask

   task automatic build_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] et);
      fr.delete();
      for (int i = 5; i >= 0; i--) fr.push_back(da[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) fr.push_back(sa[i*8 +: 8]);
      fr.push_back(et[15:8]);
      fr.push_back(et[7:0]);
      hdr_len = 14;
   endtask

   task automatic add_bytes(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) fr.push_back(base + 8'(i));
   endtask

   task automatic run_frame();
      reset_mon();
      for (int i = 0; i < fr.size(); i++) begin
         datain = fr[i];
         data_en = 1'b1;
         @(posedge clock); #1;
         observe(i);
      end
      ip_at_last = is_ip;
      data_en = 1'b0;
      datain = 8'd0;
      @(posedge clock); #1;
      observe(fr.size());
      @(posedge clock); #1;
      flag_after_end = is_ip | is_arp | is_bad;
      observe(fr.size() + 1);
   endtask

   task automatic test_reset();
      sclr = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++; if (board_mac !== 48'd0) begin n_fail++; $display("FAIL reset_board_mac got %h want 0", board_mac); end
      n_cmp++; if ({is_ip, is_arp, is_bad, pl_valid, pl_sop, runt, vlan_valid} !== 7'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0", {is_ip, is_arp, is_bad, pl_valid, pl_sop, runt, vlan_valid}); end
      n_cmp++; if (pl_len !== 11'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", pl_len); end
      sclr = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_ip();
      build_hdr(LMAC, SMAC, 16'h0800);
      add_bytes(20, 8'h00);
      run_frame();
      n_cmp++; if (first_ip_idx !== 14) begin n_fail++; $display("FAIL ip_first_cycle got %0d want 14", first_ip_idx); end
      n_cmp++; if (ip_at_last !== 1'b1) begin n_fail++; $display("FAIL ip_held got %b want 1", ip_at_last); end
      n_cmp++; if (flag_after_end !== 1'b0) begin n_fail++; $display("FAIL ip_cleared got %b want 0", flag_after_end); end
      n_cmp++; if (n_sop !== 1 || first_pl !== 8'h00) begin n_fail++; $display("FAIL ip_sop got n=%0d byte=%h want n=1 byte=00", n_sop, first_pl); end
      n_cmp++; if (n_valid !== 20 || seq_err !== 0) begin n_fail++; $display("FAIL ip_payload got n=%0d err=%0d want n=20 err=0", n_valid, seq_err); end
      n_cmp++; if (pl_len !== 11'd20) begin n_fail++; $display("FAIL ip_len got %0d want 20", pl_len); end
      n_cmp++; if (pc_mac !== SMAC || board_mac !== LMAC) begin n_fail++; $display("FAIL ip_macs got %h/%h want %h/%h", board_mac, pc_mac, LMAC, SMAC); end
      n_cmp++; if (saw_arp || saw_bad || multi_err !== 0) begin n_fail++; $display("FAIL ip_other_flags got arp=%b bad=%b multi=%0d want 0", saw_arp, saw_bad, multi_err); end
   endtask

   task automatic test_arp();
      build_hdr(48'hFFFF_FFFF_FFFF, SMAC, 16'h0806);
      add_bytes(28, 8'h40);
      run_frame();
      n_cmp++; if (saw_arp !== 1'b1 || saw_ip !== 1'b0) begin n_fail++; $display("FAIL arp_flag got arp=%b ip=%b want 1/0", saw_arp, saw_ip); end
      n_cmp++; if (n_valid !== 28 || seq_err !== 0) begin n_fail++; $display("FAIL arp_payload got n=%0d err=%0d want 28/0", n_valid, seq_err); end
      n_cmp++; if (len_at_sop !== 11'd1) begin n_fail++; $display("FAIL arp_len_reload got %0d want 1", len_at_sop); end
   endtask

   task automatic test_vlan();
      build_hdr(LMAC, SMAC, 16'h8100);
      fr.push_back(8'h20); fr.push_back(8'h64); fr.push_back(8'h08); fr.push_back(8'h00);
      hdr_len = 18;
      add_bytes(6, 8'hA0);
      run_frame();
      n_cmp++; if (vlan_valid !== 1'b1 || vlan_id !== 12'h064) begin n_fail++; $display("FAIL vlan_tag got v=%b id=%h want 1/064", vlan_valid, vlan_id); end
      n_cmp++; if (ethertype !== 16'h0800) begin n_fail++; $display("FAIL vlan_type got %h want 0800", ethertype); end
      n_cmp++; if (first_ip_idx !== 18 || first_pl !== 8'hA0 || n_valid !== 6) begin n_fail++; $display("FAIL vlan_payload got idx=%0d first=%h n=%0d want 18/a0/6", first_ip_idx, first_pl, n_valid); end
      build_hdr(LMAC, SMAC, 16'h8100);
      fr.push_back(8'h00); fr.push_back(8'h05); fr.push_back(8'h81); fr.push_back(8'h00);
      hdr_len = 18;
      add_bytes(4, 8'h10);
      run_frame();
      n_cmp++; if (saw_bad !== 1'b1 || n_valid !== 0) begin n_fail++; $display("FAIL vlan_double got bad=%b n=%0d want 1/0", saw_bad, n_valid); end
   endtask

   task automatic test_filter();
      build_hdr(48'h0200_0000_0001, SMAC, 16'h0800);
      add_bytes(10, 8'h00);
      run_frame();
      n_cmp++; if (saw_bad !== 1'b1 || saw_ip !== 1'b0 || n_valid !== 0) begin n_fail++; $display("FAIL filter_reject got bad=%b ip=%b n=%0d want 1/0/0", saw_bad, saw_ip, n_valid); end
      n_cmp++; if (saw_ip_n !== 1'b1) begin n_fail++; $display("FAIL filter_off got %b want 1", saw_ip_n); end
      n_cmp++; if (vlan_valid !== 1'b0) begin n_fail++; $display("FAIL vlan_clear got %b want 0", vlan_valid); end
   endtask

   task automatic test_runt();
      build_hdr(LMAC, SMAC, 16'h0800);
      fr = fr[0:9];
      run_frame();
      n_cmp++; if (n_runt !== 1) begin n_fail++; $display("FAIL runt_pulse got %0d want 1", n_runt); end
      n_cmp++; if (saw_ip || saw_arp || saw_bad) begin n_fail++; $display("FAIL runt_flags got %b%b%b want 000", saw_ip, saw_arp, saw_bad); end
      build_hdr(LMAC, SMAC, 16'h0800);
      add_bytes(3, 8'h55);
      run_frame();
      n_cmp++; if (saw_ip !== 1'b1 || n_valid !== 3 || n_runt !== 0) begin n_fail++; $display("FAIL runt_next got ip=%b n=%0d runt=%0d want 1/3/0", saw_ip, n_valid, n_runt); end
   endtask

   task automatic test_ipv6();
      build_hdr(LMAC, SMAC, 16'h86DD);
      add_bytes(8, 8'h00);
      run_frame();
      n_cmp++; if (saw_bad !== 1'b1 || saw_ip || n_valid !== 0) begin n_fail++; $display("FAIL ipv6 got bad=%b ip=%b n=%0d want 1/0/0", saw_bad, saw_ip, n_valid); end
   endtask

   task automatic test_zero_payload();
      build_hdr(LMAC, SMAC, 16'h0800);
      run_frame();
      n_cmp++; if (saw_ip !== 1'b1 || n_valid !== 0) begin n_fail++; $display("FAIL zero_pl got ip=%b n=%0d want 1/0", saw_ip, n_valid); end
      n_cmp++; if (pl_len !== 11'd0 || flag_after_end !== 1'b0) begin n_fail++; $display("FAIL zero_pl_len got len=%0d flag=%b want 0/0", pl_len, flag_after_end); end
   endtask

   task automatic test_sclr();
      build_hdr(LMAC, SMAC, 16'h0800);
      add_bytes(10, 8'h00);
      reset_mon();
      for (int i = 0; i < fr.size(); i++) begin
         datain = fr[i];
         data_en = 1'b1;
         sclr = (i == 5);
         @(posedge clock); #1;
         if (i == 5) begin
            n_cmp++; if (board_mac !== 48'd0 || pc_mac !== 48'd0 || ethertype !== 16'd0) begin n_fail++; $display("FAIL sclr_fields got %h %h %h want 0", board_mac, pc_mac, ethertype); end
            n_cmp++; if (pl_len !== 11'd0 || pl_valid !== 1'b0) begin n_fail++; $display("FAIL sclr_payload got len=%0d v=%b want 0/0", pl_len, pl_valid); end
         end
         observe(i);
      end
      sclr = 1'b0;
      data_en = 1'b0;
      @(posedge clock); #1;
      observe(fr.size());
      n_cmp++; if (saw_ip || saw_bad || n_valid !== 0 || n_runt !== 0) begin n_fail++; $display("FAIL sclr_ignored got ip=%b bad=%b n=%0d runt=%0d want 0", saw_ip, saw_bad, n_valid, n_runt); end
      build_hdr(LMAC, SMAC, 16'h0800);
      add_bytes(4, 8'h30);
      run_frame();
      n_cmp++; if (saw_ip !== 1'b1 || n_valid !== 4) begin n_fail++; $display("FAIL sclr_next got ip=%b n=%0d want 1/4", saw_ip, n_valid); end
   endtask

   task automatic test_saturate();
      build_hdr(LMAC, SMAC, 16'h0800);
      add_bytes(2050, 8'h00);
      run_frame();
      n_cmp++; if (pl_len !== 11'd2047 || n_valid !== 2050) begin n_fail++; $display("FAIL saturate got len=%0d n=%0d want 2047/2050", pl_len, n_valid); end
   endtask

   initial begin
      test_reset();
      test_ip();
      test_arp();
      test_vlan();
      test_filter();
      test_runt();
      test_ipv6();
      test_zero_payload();
      test_sclr();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
